grayscale_frame_sequencer: RTL and testbench
============================================

GRAYSCALE_FRAME_SEQUENCER -- requirements
Module: grayscale_frame_sequencer

Interface
REQ-001 Parameter data_width, default 8: pixel and bin-average width in bits.
REQ-002 Parameter image_width, default 320: pixels per line.
REQ-003 Parameter image_height, default 240: lines per frame.
REQ-004 Parameter bin_width, default 8: bin width; shall divide image_width exactly.
REQ-005 Parameter bin_height, default 8: bin height; shall divide image_height exactly.
REQ-006 Ports shall be as follows; one clock; reset is asynchronous and active-high.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- src_req  in  2  per-source frame request.
- src_gnt  out  2  one-hot; source owns the downsampler for one frame.
- src_valid  in  2  per-source pixel valid.
- src_data0, src_data1  in  data_width  source pixels.
- ds_reset  out  1  reset pulse to the downsampler.
- ds_in_valid, ds_in_data  out  1 / data_width  pixel stream to the downsampler.
- ds_out_valid, ds_out_data  in  1 / data_width  bin results from the downsampler.
- bin_valid, bin_data  out  1 / data_width  retimed bin results.
- bin_index  out  clog2(NUM_BINS)  raster index of the bin.
- bin_src  out  1  source that owns the bin.
- frame_done  out  1  one-cycle pulse when the frame completes.
- frame_src  out  1  source of the completed frame.
- busy  out  1  high in any state other than IDLE.

Function
REQ-007 NUM_PIX = image_width*image_height; NUM_BINS = (image_width/bin_width)*(image_height/bin_height); defaults are 76800 and 1200.
REQ-008 FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
REQ-009 IDLE: if any src_req is high, the FSM shall grant round-robin, preferring the source not granted last, and go to CLEAR; after reset, source 0 has priority.
REQ-010 CLEAR: ds_reset shall be high for exactly 1 cycle, then the FSM shall go to STREAM.
REQ-011 src_gnt shall be held one-hot from CLEAR through DONE and shall be 0 in IDLE.
REQ-012 STREAM: a granted pixel is accepted when src_valid[g] is high; accepted pixels shall drive ds_in_valid and ds_in_data registered, with 1-cycle latency; the ungranted src_valid shall be ignored.
REQ-013 After accepting NUM_PIX pixels, the FSM shall go to DRAIN; pixels offered after the last one shall be ignored.
REQ-014 The bin counter shall increment on every ds_out_valid in STREAM or DRAIN.
REQ-015 bin_valid, bin_data and bin_index shall mirror ds_out_valid and ds_out_data, plus the counter value, registered with 1-cycle latency; bin_src shall equal the granted source.
REQ-016 DRAIN shall go to DONE when the bin count reaches NUM_BINS; if the final bin arrives in STREAM, DRAIN shall last exactly 1 cycle.
REQ-017 DONE: frame_done shall pulse for 1 cycle with frame_src set; the FSM shall return to IDLE, so no back-to-back grant occurs in the same cycle.
REQ-018 ds_out_valid in IDLE or CLEAR shall be discarded, with no bin_valid asserted.
REQ-019 Pixel and bin counters shall not wrap; counting stops at NUM_PIX and NUM_BINS respectively.

Reset
REQ-020 Asserting reset shall force all outputs to 0 and the FSM to IDLE, and clear all counters and the round-robin pointer, at any time including mid-frame.
REQ-021 ds_reset shall also be high while reset is high.

Configuration
REQ-022 With macro GRAYSCALE_FRAME_SEQUENCER_TIMEOUT_EN defined: a 16-bit watchdog shall count consecutive DRAIN cycles without ds_out_valid; at 65535 it shall force DONE, pulse frame_done, and set a sticky output timeout_err, cleared only by reset.
REQ-023 Without GRAYSCALE_FRAME_SEQUENCER_TIMEOUT_EN: no watchdog logic and no timeout_err port; DRAIN waits indefinitely.

Structure
REQ-024 The state enum and the NUM_PIX/NUM_BINS derivation functions shall live in package grayscale_seq_pkg.
REQ-025 The round-robin grant logic shall be sub-module frame_rr_arbiter: 2 requesters, updated only on grant.

Verification
REQ-026 Test 1: reset, then src_req=01 with 76800 pixels on 1/3-random valid into a real downsampler -> 1200 bin_valid pulses, bin_index 0..1199, one frame_done with frame_src=0.
REQ-027 Test 2: both src_req held high for 3 frames -> grants alternate 0,1,0; src_gnt is 0 for at least 1 cycle between frames.
REQ-028 Test 3: src1 toggles src_valid while src0 is granted -> ds_in_valid count equals src0 accepted pixels only (76800).
REQ-029 Test 4: reset asserted after 1000 pixels -> next cycle all outputs are 0, state is IDLE; a fresh frame then completes with 1200 bins.
REQ-030 Test 5: ds_out_valid pulsed in IDLE -> no bin_valid; stray pixels after pixel 76800 -> not forwarded.
REQ-031 Test 6, with GRAYSCALE_FRAME_SEQUENCER_TIMEOUT_EN: downsampler stub withholds the last bin -> frame_done and timeout_err exactly 65535 cycles after the last ds_out_valid.

Source files
------------

// File: rtl/grayscale_seq_pkg.sv
// Shared types and size helpers for the grayscale frame sequencer.
// Holds the FSM state enum, grant bundle and NUM_PIX/NUM_BINS derivation.
package grayscale_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic valid;
    logic idx;
  } grant_t;

  function automatic int num_pix(int w, int h);
    return w * h;
  endfunction

  function automatic int num_bins(int w, int h, int bw, int bh);
    return (w / bw) * (h / bh);
  endfunction

  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/grayscale_frame_sequencer_arbiter.sv
// frame_rr_arbiter: two-requester round-robin for frame ownership.
// Ports: clock, reset, en (sequencer idle), req[1:0], gnt {valid, idx}.
module frame_rr_arbiter
  import grayscale_seq_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output grant_t     gnt
);

  // prio names the source that wins a tie; it flips to
  // the other source each time a grant is issued.
  logic prio;

  always_comb begin
    gnt = '0;
    if (en) begin
      if (req[prio]) begin
        gnt.valid = 1'b1;
        gnt.idx   = prio;
      end else if (req[~prio]) begin
        gnt.valid = 1'b1;
        gnt.idx   = ~prio;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      prio <= 1'b0;
    else if (gnt.valid)
      prio <= ~gnt.idx;
  end

endmodule

// File: rtl/grayscale_frame_sequencer.sv
// Grayscale frame sequencer: grants one of two sources per frame, streams
// its pixels to a downsampler and retimes the bin results with raster index.
// Ports: clock/reset, src_req/gnt/valid/data0/data1, ds_reset, ds_in_*,
// ds_out_*, bin_valid/data/index/src, frame_done/src, busy.
// Optional GRAYSCALE_FRAME_SEQUENCER_TIMEOUT_EN adds a DRAIN watchdog
// and the sticky timeout_err output.
module grayscale_frame_sequencer
  import grayscale_seq_pkg::*;
#(
  parameter int data_width   = 8,
  parameter int image_width  = 320,
  parameter int image_height = 240,
  parameter int bin_width    = 8,
  parameter int bin_height   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            src_req,
  output logic [1:0]            src_gnt,
  input  logic [1:0]            src_valid,
  input  logic [data_width-1:0] src_data0,
  input  logic [data_width-1:0] src_data1,
  output logic                  ds_reset,
  output logic                  ds_in_valid,
  output logic [data_width-1:0] ds_in_data,
  input  logic                  ds_out_valid,
  input  logic [data_width-1:0] ds_out_data,
  output logic                  bin_valid,
  output logic [data_width-1:0] bin_data,
  output logic [idx_width(num_bins(image_width, image_height,
                 bin_width, bin_height))-1:0] bin_index,
  output logic                  bin_src,
  output logic                  frame_done,
  output logic                  frame_src,
`ifdef GRAYSCALE_FRAME_SEQUENCER_TIMEOUT_EN
  output logic                  timeout_err,
`endif
  output logic                  busy
);

  localparam int NPIX = num_pix(image_width, image_height);
  localparam int NBIN = num_bins(image_width, image_height,
                                 bin_width, bin_height);
  localparam int IW   = idx_width(NBIN);
  localparam int PCW  = $clog2(NPIX + 1);
  localparam int BCW  = $clog2(NBIN + 1);

  seq_state_t            state, state_n;
  grant_t                arb;
  logic                  gsrc;
  logic [PCW-1:0]        pix_cnt;
  logic [BCW-1:0]        bin_cnt;
  logic                  accept;
  logic                  last_pix;
  logic                  bins_full;
  logic                  bin_take;
  logic                  timeout_hit;
  logic [data_width-1:0] pix_data;

  frame_rr_arbiter u_arb (
    .clock (clock),
    .reset (reset),
    .en    (state == IDLE),
    .req   (src_req),
    .gnt   (arb)
  );

  assign pix_data  = gsrc ? src_data1 : src_data0;
  assign accept    = (state == STREAM) && src_valid[gsrc]
                     && (pix_cnt < PCW'(NPIX));
  assign last_pix  = accept && (pix_cnt == PCW'(NPIX - 1));
  assign bins_full = (bin_cnt == BCW'(NBIN));
  assign bin_take  = ((state == STREAM) || (state == DRAIN))
                     && ds_out_valid && !bins_full;

`ifdef GRAYSCALE_FRAME_SEQUENCER_TIMEOUT_EN
  logic [15:0] wdog;

  // wdog holds the idle DRAIN cycles before the current one, so firing
  // at 65533 lands DONE 65535 cycles after the last bin.
  assign timeout_hit = (state == DRAIN) && !ds_out_valid
                       && (wdog == 16'hFFFD);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else begin
      if ((state == DRAIN) && !ds_out_valid)
        wdog <= wdog + 16'd1;
      else
        wdog <= '0;
      if (timeout_hit)
        timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (arb.valid) state_n = CLEAR;
      CLEAR:   state_n = STREAM;
      STREAM:  if (last_pix) state_n = DRAIN;
      DRAIN:   if (bins_full || timeout_hit) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gsrc        <= 1'b0;
      pix_cnt     <= '0;
      bin_cnt     <= '0;
      ds_in_valid <= 1'b0;
      ds_in_data  <= '0;
      bin_valid   <= 1'b0;
      bin_data    <= '0;
      bin_index   <= '0;
      bin_src     <= 1'b0;
    end else begin
      if ((state == IDLE) && arb.valid)
        gsrc <= arb.idx;
      if (state == CLEAR) begin
        pix_cnt <= '0;
        bin_cnt <= '0;
      end else begin
        if (accept)
          pix_cnt <= pix_cnt + PCW'(1);
        if (bin_take)
          bin_cnt <= bin_cnt + BCW'(1);
      end
      ds_in_valid <= accept;
      if (accept)
        ds_in_data <= pix_data;
      bin_valid <= bin_take;
      if (bin_take) begin
        bin_data  <= ds_out_data;
        bin_index <= bin_cnt[IW-1:0];
      end
      bin_src <= gsrc;
    end
  end

  assign src_gnt    = (state == IDLE) ? 2'b00 : {gsrc, ~gsrc};
  assign ds_reset   = reset | (state == CLEAR);
  assign frame_done = (state == DONE);
  assign frame_src  = frame_done & gsrc;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_grayscale_frame_sequencer.sv
// Self-checking bench for grayscale_frame_sequencer on a small 16x8 image
// with 4x4 bins, driving a behavioural averaging downsampler.
module tb_grayscale_frame_sequencer;

  localparam int W    = 16;
  localparam int H    = 8;
  localparam int BW   = 4;
  localparam int BH   = 4;
  localparam int DW   = 8;
  localparam int NPIX = W * H;
  localparam int NBIN = (W / BW) * (H / BH);
  localparam int IW   = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    src_req = '0;
  logic [1:0]    src_gnt;
  logic [1:0]    src_valid = '0;
  logic [DW-1:0] src_data0 = '0;
  logic [DW-1:0] src_data1 = '0;
  logic          ds_reset;
  logic          ds_in_valid;
  logic [DW-1:0] ds_in_data;
  logic          ds_out_valid;
  logic [DW-1:0] ds_out_data;
  logic          bin_valid;
  logic [DW-1:0] bin_data;
  logic [IW-1:0] bin_index;
  logic          bin_src;
  logic          frame_done;
  logic          frame_src;
  logic          busy;
`ifdef GRAYSCALE_FRAME_SEQUENCER_TIMEOUT_EN
  logic          timeout_err;
`endif

  grayscale_frame_sequencer #(
    .data_width   (DW),
    .image_width  (W),
    .image_height (H),
    .bin_width    (BW),
    .bin_height   (BH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .src_req      (src_req),
    .src_gnt      (src_gnt),
    .src_valid    (src_valid),
    .src_data0    (src_data0),
    .src_data1    (src_data1),
    .ds_reset     (ds_reset),
    .ds_in_valid  (ds_in_valid),
    .ds_in_data   (ds_in_data),
    .ds_out_valid (ds_out_valid),
    .ds_out_data  (ds_out_data),
    .bin_valid    (bin_valid),
    .bin_data     (bin_data),
    .bin_index    (bin_index),
    .bin_src      (bin_src),
    .frame_done   (frame_done),
    .frame_src    (frame_src),
`ifdef GRAYSCALE_FRAME_SEQUENCER_TIMEOUT_EN
    .timeout_err  (timeout_err),
`endif
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act,
                       input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Behavioural downsampler: averages each BWxBH tile and emits it when
  // the tile's last pixel arrives. Runs on the falling edge.
  logic          ds_ov = 1'b0;
  logic [DW-1:0] ds_od = '0;
  logic          inj = 1'b0;
  bit            withhold = 1'b0;
  int            ds_cnt = 0;
  int            ds_x, ds_y, ds_b;
  int            acc [NBIN];

  assign ds_out_valid = ds_ov | inj;
  assign ds_out_data  = ds_od;

  always @(negedge clock) begin
    ds_ov <= 1'b0;
    if (ds_reset) begin
      ds_cnt = 0;
      foreach (acc[i]) acc[i] = 0;
    end else if (ds_in_valid) begin
      ds_x = ds_cnt % W;
      ds_y = ds_cnt / W;
      ds_b = (ds_y / BH) * (W / BW) + ds_x / BW;
      acc[ds_b] += int'(ds_in_data);
      if ((ds_x % BW == BW - 1) && (ds_y % BH == BH - 1)
          && !(withhold && ds_b >= NBIN - 2)) begin
        ds_ov <= 1'b1;
        ds_od <= DW'(acc[ds_b] / (BW * BH));
      end
      ds_cnt++;
    end
  end

  typedef struct {
    int idx;
    int data;
    int src;
  } bin_rec_t;

  bin_rec_t binq[$];
  int din_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_ov = 0;
  int frame_pix [NPIX];

  always @(negedge clock) begin
    if (bin_valid)
      binq.push_back('{int'(bin_index), int'(bin_data), int'(bin_src)});
    if (ds_in_valid) din_cnt++;
    if (frame_done) done_cnt++;
  end

  always @(posedge clock) begin
    if (ds_out_valid) last_ov = cyc;
    cyc++;
  end

  task automatic drive_pixel(input int g, input bit v,
                             input logic [DW-1:0] d);
    logic [DW-1:0] o;
    bit ov;
    o  = DW'($urandom_range(255));
    ov = 1'($urandom_range(1));
    if (g == 0) begin
      src_valid = {ov, v};
      src_data0 = d;
      src_data1 = o;
    end else begin
      src_valid = {v, ov};
      src_data1 = d;
      src_data0 = o;
    end
  endtask

  // Offers n pixels from source g on ~1/3 of cycles; called in STREAM.
  task automatic stream(input string tag, input int g, input int n);
    int sent = 0;
    int w = 0;
    bit v;
    logic [DW-1:0] d;
    while (sent < n && w < n * 20) begin
      v = ($urandom_range(2) == 0);
      d = DW'($urandom_range(255));
      drive_pixel(g, v, d);
      if (v) begin
        frame_pix[sent] = int'(d);
        sent++;
      end
      @(negedge clock);
      w++;
    end
    src_valid = '0;
    check({tag, "_sent"}, sent, n);
  endtask

  task automatic wait_grant(input logic [1:0] req);
    int w = 0;
    src_req = req;
    do begin
      @(negedge clock);
      w++;
    end while (!busy && w < 20);
  endtask

  task automatic run_frame(input logic [1:0] req, input int exp_src,
                           input string tag);
    int w = 0;
    int s;
    binq.delete();
    din_cnt  = 0;
    done_cnt = 0;
    wait_grant(req);
    check({tag, "_gnt"}, src_gnt, 1 << exp_src);
    check({tag, "_dsrst"}, ds_reset, 1);
    src_valid = '0;
    @(negedge clock);
    stream(tag, exp_src, NPIX);
    while (!frame_done && w < 200) begin
      drive_pixel(exp_src, 1'($urandom_range(1)),
                  DW'($urandom_range(255)));
      @(negedge clock);
      w++;
    end
    check({tag, "_done"}, frame_done, 1);
    check({tag, "_fsrc"}, frame_src, exp_src);
    src_valid = '0;
    @(negedge clock);
    check({tag, "_gap_gnt"}, src_gnt, 0);
    check({tag, "_gap_busy"}, busy, 0);
    check({tag, "_ndone"}, done_cnt, 1);
    check({tag, "_nds_in"}, din_cnt, NPIX);
    check({tag, "_nbins"}, binq.size(), NBIN);
    for (int b = 0; b < NBIN; b++) begin
      s = 0;
      for (int y = 0; y < BH; y++)
        for (int x = 0; x < BW; x++)
          s += frame_pix[((b / (W / BW)) * BH + y) * W
                         + (b % (W / BW)) * BW + x];
      if (b < binq.size()) begin
        check($sformatf("%s_idx%0d", tag, b), binq[b].idx, b);
        check($sformatf("%s_dat%0d", tag, b), binq[b].data,
              s / (BW * BH));
        check($sformatf("%s_src%0d", tag, b), binq[b].src, exp_src);
      end
    end
  endtask

  task automatic check_outs(input string tag, input int exp_dsr);
    check({tag, "_dsrst"}, ds_reset, exp_dsr);
    check({tag, "_outs"},
          {src_gnt, ds_in_valid, ds_in_data, bin_valid, bin_data,
           bin_index, bin_src, frame_done, frame_src, busy}, 0);
`ifdef GRAYSCALE_FRAME_SEQUENCER_TIMEOUT_EN
    check({tag, "_terr"}, timeout_err, 0);
`endif
  endtask

  typedef struct {
    logic [1:0] req;
    int         exp_src;
  } frame_vec_t;

  frame_vec_t tab [7];

  initial begin
    tab[0] = '{2'b11, 0};
    tab[1] = '{2'b11, 1};
    tab[2] = '{2'b11, 0};
    tab[3] = '{2'b01, 0};
    tab[4] = '{2'b10, 1};
    tab[5] = '{2'b11, 0};
    tab[6] = '{2'b10, 1};

    repeat (2) @(negedge clock);
    check_outs("in_rst", 1);
    reset = 1'b0;
    @(negedge clock);
    check_outs("rst_rel", 0);

    binq.delete();
    inj = 1'b1;
    @(negedge clock);
    inj = 1'b0;
    @(negedge clock);
    check("idle_ov_bins", binq.size(), 0);
    check("idle_ov_busy", busy, 0);

    for (int i = 0; i < 7; i++)
      run_frame(tab[i].req, tab[i].exp_src, $sformatf("f%0d", i));
    src_req = '0;
    @(negedge clock);

    wait_grant(2'b01);
    check("mid_gnt", src_gnt, 2'b01);
    src_valid = '0;
    @(negedge clock);
    stream("mid", 0, 40);
    src_req = '0;
    reset = 1'b1;
    @(negedge clock);
    check_outs("mid_rst", 1);
    reset = 1'b0;
    @(negedge clock);
    check_outs("mid_rel", 0);
    run_frame(2'b11, 0, "post_rst");
    src_req = '0;

`ifdef GRAYSCALE_FRAME_SEQUENCER_TIMEOUT_EN
    begin
      int w = 0;
      int done_cyc = 0;
      withhold = 1'b1;
      wait_grant(2'b01);
      src_valid = '0;
      @(negedge clock);
      stream("wd", 0, NPIX);
      repeat (3) @(negedge clock);
      inj = 1'b1;
      @(negedge clock);
      inj = 1'b0;
      while (!frame_done && w < 70000) begin
        @(negedge clock);
        w++;
      end
      done_cyc = cyc;
      src_req = '0;
      check("wd_done", frame_done, 1);
      check("wd_delay", done_cyc - last_ov, 65535);
      check("wd_terr", timeout_err, 1);
      withhold = 1'b0;
      @(negedge clock);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
